// File: rtl/tl_rx_tlp_router_pkg.sv
// tl_rx_tlp_router_pkg: egress classes, TLP fmt/type codes and the expected-beat-count helper
package tl_rx_tlp_router_pkg;
  typedef enum logic [1:0] {EG_MEM, EG_CPL, EG_CFG, EG_DROP} eg_class_e;
  localparam logic [2:0] FMT_3DW_ND = 3'b000;
  localparam logic [2:0] FMT_4DW_ND = 3'b001;
  localparam logic [2:0] FMT_3DW_D  = 3'b010;
  localparam logic [2:0] FMT_4DW_D  = 3'b011;
  localparam logic [4:0] TYPE_MRD   = 5'b00000;
  localparam logic [4:0] TYPE_CPL   = 5'b01010;
  localparam logic [4:0] TYPE_CFG0  = 5'b00100;
  // fmt[0] selects a 4DW header, fmt[1] marks a payload; len=0 encodes 1024 DW
  function automatic logic [11:0] tlp_exp_beats(input logic [1:0] fmt, input logic [9:0] len, input int data_w);
    logic [11:0] dw, dpb;
    dpb = 12'(data_w / 32);
    dw = (fmt[0] ? 12'd4 : 12'd3) + (fmt[1] ? (len == 10'd0 ? 12'd1024 : 12'(len)) : 12'd0);
    return (dw + dpb - 12'd1) / dpb;
  endfunction
endpackage

// File: rtl/tl_rx_tlp_router_if.sv
// tl_rx_tlp_router_if: DLL RX beat stream in, one-hot classed egress stream out
interface tl_rx_tlp_router_if #(
  parameter int DATA_W = 128,
  parameter int N_EG = 3
);
  logic [DATA_W-1:0] rx_data_i;
  logic              rx_sop_i;
  logic              rx_eop_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic [DATA_W-1:0] eg_data_o;
  logic              eg_sop_o;
  logic              eg_eop_o;
  logic              eg_err_o;
  logic [N_EG-1:0]   eg_valid_o;
  logic [N_EG-1:0]   eg_ready_i;
  modport master (
    output rx_data_i, rx_sop_i, rx_eop_i, rx_valid_i, eg_ready_i,
    input  rx_ready_o, eg_data_o, eg_sop_o, eg_eop_o, eg_err_o, eg_valid_o
  );
  modport slave (
    input  rx_data_i, rx_sop_i, rx_eop_i, rx_valid_i, eg_ready_i,
    output rx_ready_o, eg_data_o, eg_sop_o, eg_eop_o, eg_err_o, eg_valid_o
  );
endinterface

// File: rtl/tl_rx_tlp_router_hdr_classify.sv
// tl_rx_tlp_router_hdr_classify: maps SOP header fmt/type/len to an egress class and expected beat count
module tl_rx_tlp_router_hdr_classify
  import tl_rx_tlp_router_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic [2:0]  fmt,
  input  logic [4:0]  typ,
  input  logic [9:0]  len,
  output eg_class_e   cls,
  output logic [11:0] exp_beats
);
  logic hdr3;
  always_comb begin
    hdr3 = fmt == FMT_3DW_ND || fmt == FMT_3DW_D;
    cls = (typ == TYPE_MRD && !fmt[2]) ? EG_MEM :
          (typ == TYPE_CPL && hdr3)    ? EG_CPL :
          (typ == TYPE_CFG0 && hdr3)   ? EG_CFG : EG_DROP;
    exp_beats = tlp_exp_beats(fmt[1:0], len, DATA_W);
  end
endmodule

// File: rtl/tl_rx_tlp_router.sv
// tl_rx_tlp_router: steers whole RX TLPs to MEM/CPL/CFG egress classes through a one-beat output slot,
// dropping unsupported TLPs and flagging beat counts that disagree with the header length.
module tl_rx_tlp_router
  import tl_rx_tlp_router_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int N_EG = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  tl_rx_tlp_router_if.slave bus,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] malf_cnt_o
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  logic [1:0] state;
  eg_class_e cur_cls, tlp_cls, out_cls;
  logic [11:0] cur_exp, exp_beats, cnt, cnt_nx;
  logic over, out_vld, out_sop, out_eop, out_err, sel_rdy, acc, sop, fwd, err, abandon, drop_ev;
  logic [DATA_W-1:0] out_data;
  logic [N_EG-1:0] out_sel;
  logic [CNT_W:0] malf_sum;

  tl_rx_tlp_router_hdr_classify #(.DATA_W(DATA_W)) u_classify (
    .fmt(bus.rx_data_i[DATA_W-1 -: 3]),
    .typ(bus.rx_data_i[DATA_W-4 -: 5]),
    .len(bus.rx_data_i[DATA_W-23 -: 10]),
    .cls(cur_cls),
    .exp_beats(cur_exp)
  );

  // Length checking applies to routed TLPs only; dropped TLPs are just counted and consumed.
  always_comb begin
    out_sel = out_vld ? {{(N_EG-1){1'b0}}, 1'b1} << out_cls : '0;
    sel_rdy = |(bus.eg_ready_i & out_sel);
    bus.rx_ready_o = !out_vld || sel_rdy;
    acc = bus.rx_valid_i && bus.rx_ready_o;
    sop = acc && bus.rx_sop_i;
    fwd = sop ? cur_cls != EG_DROP : acc && state == ST_FWD;
    cnt_nx = sop ? 12'd1 : cnt + 12'd1;
    err = bus.rx_eop_i && (sop ? cur_exp != 12'd1 : over || cnt_nx != exp_beats);
    abandon = sop && state != ST_IDLE;
    drop_ev = sop && cur_cls == EG_DROP;
    malf_sum = {1'b0, malf_cnt_o} + (CNT_W+1)'(abandon) + (CNT_W+1)'(fwd && err);
    bus.eg_valid_o = out_sel;
    bus.eg_data_o = out_data;
    bus.eg_sop_o = out_sop;
    bus.eg_eop_o = out_eop;
    bus.eg_err_o = out_err;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      tlp_cls <= EG_MEM;
      exp_beats <= '0;
      cnt <= '0;
      over <= 1'b0;
    end else if (acc) begin
      state <= bus.rx_eop_i ? ST_IDLE : sop ? (cur_cls == EG_DROP ? ST_DROP : ST_FWD) : state;
      cnt <= cnt_nx;
      over <= !sop && (over || cnt_nx > exp_beats);
      if (sop) begin
        tlp_cls <= cur_cls;
        exp_beats <= cur_exp;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_cls <= EG_MEM;
      out_data <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_err <= 1'b0;
    end else if (fwd) begin
      out_vld <= 1'b1;
      out_cls <= sop ? cur_cls : tlp_cls;
      out_data <= bus.rx_data_i;
      out_sop <= bus.rx_sop_i;
      out_eop <= bus.rx_eop_i;
      out_err <= err;
    end else if (sel_rdy) begin
      out_vld <= 1'b0;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      drop_cnt_o <= '0;
      malf_cnt_o <= '0;
    end else begin
      if (drop_ev && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
      malf_cnt_o <= malf_sum[CNT_W] ? '1 : malf_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_tl_rx_tlp_router.sv
// tb_tl_rx_tlp_router: directed and randomized TLP traffic checked against a packet-level reference model
module tb_tl_rx_tlp_router;
  localparam int DATA_W = 128;
  localparam int N_EG = 3;
  localparam int CNT_W = 16;
  localparam logic [7:0] KINDS [11] = '{8'b000_00000, 8'b001_00000, 8'b010_00000, 8'b011_00000,
    8'b000_01010, 8'b010_01010, 8'b000_00100, 8'b010_00100, 8'b001_10000, 8'b011_00100, 8'b001_01010};

  typedef struct {
    int cls;
    logic [DATA_W-1:0] data;
    logic sop, eop, err;
    int cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] drop_cnt, malf_cnt;
  logic [2:0] rdy_fix = 3'b111;
  bit rnd_bp = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  int m_drop = 0, m_malf = 0, m_n = 0, m_exp = 0, m_cls = 0;
  bit m_in = 1'b0, m_dropping = 1'b0;
  beat_t exp_q[$];

  tl_rx_tlp_router_if #(.DATA_W(DATA_W), .N_EG(N_EG)) bus();

  tl_rx_tlp_router #(.DATA_W(DATA_W), .N_EG(N_EG), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .drop_cnt_o(drop_cnt),
    .malf_cnt_o(malf_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus.eg_ready_i = rnd_bp ? 3'($urandom) : rdy_fix;
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic int decode(input logic [31:0] dw0);
    logic [2:0] f;
    logic [4:0] t;
    f = dw0[31:29];
    t = dw0[28:24];
    if (t == 5'b00000 && f inside {3'b000, 3'b001, 3'b010, 3'b011}) return 0;
    if (t == 5'b01010 && f inside {3'b000, 3'b010}) return 1;
    if (t == 5'b00100 && f inside {3'b000, 3'b010}) return 2;
    return 3;
  endfunction

  function automatic int beats_for(input logic [2:0] f, input int len);
    int lf, hdr, dat;
    lf = len % 1024;
    hdr = f[0] ? 4 : 3;
    dat = f[1] ? (lf == 0 ? 1024 : lf) : 0;
    return ((hdr + dat) * 32 + DATA_W - 1) / DATA_W;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push(input logic [DATA_W-1:0] d, input logic s, input logic e);
    logic er;
    er = e && m_n != m_exp;
    if (er) m_malf++;
    exp_q.push_back('{m_cls, d, s, e, er, cyc + 1});
  endtask

  task automatic model_accept(input logic [DATA_W-1:0] d, input logic s, input logic e);
    if (s) begin
      if (m_in) m_malf++;
      m_cls = decode(d[DATA_W-1 -: 32]);
      m_in = !e;
      m_dropping = m_cls == 3;
      if (m_dropping) m_drop++;
      else begin
        m_n = 1;
        m_exp = beats_for(d[DATA_W-1 -: 3], int'(d[DATA_W-23 -: 10]));
        push(d, s, e);
      end
    end else if (m_in) begin
      m_n++;
      if (!m_dropping) push(d, s, e);
      if (e) m_in = 1'b0;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic s, input logic e, output int waits);
    int g;
    g = 0;
    @(negedge clk);
    bus.rx_data_i = d;
    bus.rx_sop_i = s;
    bus.rx_eop_i = e;
    bus.rx_valid_i = 1'b1;
    while (!bus.rx_ready_o && g < 2000) begin
      @(negedge clk);
      g++;
    end
    waits = g;
    if (!bus.rx_ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual ready=0 required ready=1 after %0d cycles", g);
    end else model_accept(d, s, e);
    @(posedge clk);
    #1 bus.rx_valid_i = 1'b0;
  endtask

  task automatic tlp(input logic [2:0] f, input logic [4:0] t, input int len, input int nb, input bit no_eop, input bit tput);
    int w;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < nb; i++) begin
      d = rnd_beat();
      if (i == 0) d[DATA_W-1 -: 32] = {f, t, 14'd0, 10'(len)};
      if (!tput && $urandom_range(0, 3) == 0) @(negedge clk);
      send(d, i == 0, i == nb - 1 && !no_eop, w);
      if (tput) chk("rx_ready_no_wait", 128'(w), 128'd0);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    rnd_bp = 1'b0;
    rdy_fix = 3'b111;
    while ((exp_q.size() != 0 || bus.eg_valid_o != 0) && g < 400) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk("drain_done", 128'(exp_q.size()), 128'd0);
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    chk("malf_cnt", 128'(malf_cnt), 128'(m_malf));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rx_ready", 128'(bus.rx_ready_o), 128'd1);
    chk("rst_eg_valid", 128'(bus.eg_valid_o), 128'd0);
    chk("rst_eg_data", bus.eg_data_o, 128'd0);
    chk("rst_eg_flags", 128'({bus.eg_sop_o, bus.eg_eop_o, bus.eg_err_o}), 128'd0);
    chk("rst_drop_cnt", 128'(drop_cnt), 128'd0);
    chk("rst_malf_cnt", 128'(malf_cnt), 128'd0);
  endtask

  // Monitor: a beat is popped the first cycle it appears; while stalled it must hold still.
  initial begin
    logic [DATA_W-1:0] h_data;
    logic [2:0] h_v;
    logic h_sop, h_eop, h_err;
    bit stalled;
    beat_t e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 1'b0;
      else begin
        if (stalled) begin
          chk("stall_valid", 128'(bus.eg_valid_o), 128'(h_v));
          chk("stall_data", bus.eg_data_o, h_data);
          chk("stall_flags", 128'({bus.eg_sop_o, bus.eg_eop_o, bus.eg_err_o}), 128'({h_sop, h_eop, h_err}));
        end
        if (bus.eg_valid_o != 0) begin
          chk("valid_onehot", 128'($onehot(bus.eg_valid_o)), 128'd1);
          if (!stalled) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat actual valid=%b required none", bus.eg_valid_o);
            end else begin
              e = exp_q.pop_front();
              chk("eg_class", 128'(bus.eg_valid_o), 128'(3'b001 << e.cls));
              chk("eg_data", bus.eg_data_o, e.data);
              chk("eg_sop_eop", 128'({bus.eg_sop_o, bus.eg_eop_o}), 128'({e.sop, e.eop}));
              chk("eg_err", 128'(bus.eg_err_o), 128'(e.err));
              chk("latency", 128'(cyc), 128'(e.cyc));
            end
          end
          stalled = (bus.eg_valid_o & bus.eg_ready_i) == 0;
          h_v = bus.eg_valid_o;
          h_data = bus.eg_data_o;
          h_sop = bus.eg_sop_o;
          h_eop = bus.eg_eop_o;
          h_err = bus.eg_err_o;
        end else stalled = 1'b0;
      end
    end
  end

  initial begin
    int w;
    bus.rx_data_i = '0;
    bus.rx_sop_i = 1'b0;
    bus.rx_eop_i = 1'b0;
    bus.rx_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tlp(3'b010, 5'b00000, 8, 3, 1'b0, 1'b1);
    tlp(3'b010, 5'b01010, 1, 1, 1'b0, 1'b1);
    send(rnd_beat(), 1'b0, 1'b1, w);
    tlp(3'b001, 5'b10000, 0, 2, 1'b0, 1'b1);
    drain();
    chk("msg_drop_cnt", 128'(drop_cnt), 128'd1);
    rdy_fix = 3'b011;
    repeat (2) @(posedge clk);
    tlp(3'b010, 5'b00100, 1, 1, 1'b0, 1'b1);
    @(negedge clk);
    chk("stall_rx_ready", 128'(bus.rx_ready_o), 128'd0);
    fork
      begin
        repeat (5) @(posedge clk);
        rdy_fix = 3'b111;
      end
      tlp(3'b010, 5'b00100, 1, 1, 1'b0, 1'b0);
    join
    drain();
    tlp(3'b010, 5'b00000, 8, 2, 1'b0, 1'b1);
    tlp(3'b010, 5'b00000, 8, 1, 1'b1, 1'b1);
    tlp(3'b000, 5'b00000, 1, 1, 1'b0, 1'b1);
    drain();
    chk("malf_after_short_and_abandon", 128'(malf_cnt), 128'd2);
    tlp(3'b010, 5'b00000, 0, beats_for(3'b010, 0), 1'b0, 1'b1);
    tlp(3'b000, 5'b00000, 0, 1, 1'b0, 1'b1);
    tlp(3'b011, 5'b00000, 1, 2, 1'b0, 1'b1);
    drain();
    tlp(3'b010, 5'b00000, 8, 1, 1'b1, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    m_in = 1'b0;
    m_drop = 0;
    m_malf = 0;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(rnd_beat(), 1'b0, 1'b0, w);
    send(rnd_beat(), 1'b0, 1'b1, w);
    drain();
    tlp(3'b010, 5'b00000, 8, 3, 1'b0, 1'b1);
    drain();
    rnd_bp = 1'b1;
    for (int t = 0; t < 80; t++) begin
      logic [2:0] f;
      logic [4:0] ty;
      int len, nb, r;
      bit ne;
      {f, ty} = KINDS[$urandom_range(0, 10)];
      len = $urandom_range(1, 24);
      nb = beats_for(f, len);
      r = $urandom_range(0, 9);
      ne = 1'b0;
      if (r == 0) nb++;
      else if (r == 1 && nb > 1) nb--;
      else if (r == 2) ne = 1'b1;
      if ($urandom_range(0, 6) == 0) send(rnd_beat(), 1'b0, 1'($urandom_range(0, 1)), w);
      rnd_bp = 1'b1;
      tlp(f, ty, len, nb, ne, 1'b0);
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
